// File: rtl/regfile_mp.sv
// Multi-port register file with a post-reset index-preload sweep, registered reads,
// write-to-read bypass and same-address write conflict flag. Optional: REGFILE_TRACE_EN.
module regfile_mp #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned NREAD   = 2,
    parameter int unsigned NWRITE  = 2,
    parameter bit          ZERO_R0 = 1'b1
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [NREAD*ADDR_W-1:0]    i_rd_addr,
    output logic [NREAD*DATA_W-1:0]    o_rd_data,
    input  logic [NWRITE-1:0]          i_wr_en,
    input  logic [NWRITE*ADDR_W-1:0]   i_wr_addr,
    input  logic [NWRITE*DATA_W-1:0]   i_wr_data,
    output logic                       o_ready,
    output logic                       o_wr_conflict
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    if (DATA_W < ADDR_W) begin : g_err_width
        $error("regfile_mp: DATA_W must be >= ADDR_W");
    end
    if (NREAD < 1 || NREAD > 4) begin : g_err_nread
        $error("regfile_mp: NREAD must be 1..4");
    end
    if (NWRITE < 1 || NWRITE > 2) begin : g_err_nwrite
        $error("regfile_mp: NWRITE must be 1..2");
    end

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e                    r_state;
    state_e                    w_state_nxt;
    logic [ADDR_W-1:0]         r_init_cnt;
    logic [ADDR_W-1:0]         w_init_cnt_nxt;
    logic                      r_ready;
    logic                      r_wr_conflict;
    logic [NREAD*DATA_W-1:0]   r_rd_data;
    logic [NREAD*DATA_W-1:0]   w_rd_nxt;

    logic [DATA_W-1:0]         r_regs [DEPTH];

    logic [ADDR_W-1:0]         w_waddr [NWRITE];
    logic [DATA_W-1:0]         w_wdata [NWRITE];
    logic [ADDR_W-1:0]         w_raddr [NREAD];
    logic [NWRITE-1:0]         w_wvalid;
    logic [NWRITE-1:0]         w_commit;
    logic                      w_conflict;

    always_comb begin
        for (int p = 0; p < NWRITE; p++) begin
            w_waddr[p]  = i_wr_addr[p*ADDR_W +: ADDR_W];
            w_wdata[p]  = i_wr_data[p*DATA_W +: DATA_W];
            w_wvalid[p] = (r_state == StRun) && i_wr_en[p] &&
                          !(ZERO_R0 && (w_waddr[p] == '0));
        end
        for (int k = 0; k < NREAD; k++) begin
            w_raddr[k] = i_rd_addr[k*ADDR_W +: ADDR_W];
        end
    end

    if (NWRITE == 2) begin : g_conflict
        assign w_conflict = w_wvalid[0] && w_wvalid[1] && (w_waddr[0] == w_waddr[1]);
    end else begin : g_no_conflict
        assign w_conflict = 1'b0;
    end

    // Port 1 wins a same-address collision, so port 0 is not committed at all.
    always_comb begin
        w_commit = w_wvalid;
        if (w_conflict) begin
            w_commit[0] = 1'b0;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_init_cnt_nxt = r_init_cnt;
        case (r_state)
            StInit: begin
                w_init_cnt_nxt = r_init_cnt + 1'b1;
                if (r_init_cnt == '1) begin
                    w_state_nxt = StRun;
                end
            end
            StRun:   w_state_nxt = StRun;
            default: w_state_nxt = StInit;
        endcase
    end

    always_comb begin
        w_rd_nxt = '0;
        for (int k = 0; k < NREAD; k++) begin
            w_rd_nxt[k*DATA_W +: DATA_W] = r_regs[w_raddr[k]];
            for (int p = 0; p < NWRITE; p++) begin
                if (w_commit[p] && (w_waddr[p] == w_raddr[k])) begin
                    w_rd_nxt[k*DATA_W +: DATA_W] = w_wdata[p];
                end
            end
            if ((r_state != StRun) || (ZERO_R0 && (w_raddr[k] == '0))) begin
                w_rd_nxt[k*DATA_W +: DATA_W] = '0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= StInit;
            r_init_cnt    <= '0;
            r_ready       <= 1'b0;
            r_wr_conflict <= 1'b0;
            r_rd_data     <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_init_cnt    <= w_init_cnt_nxt;
            r_ready       <= (w_state_nxt == StRun);
            r_wr_conflict <= w_conflict;
            r_rd_data     <= w_rd_nxt;
        end
    end

    // Zero-extended index also yields 0 for register 0, so ZERO_R0 needs no special case here.
    always_ff @(posedge i_clk) begin
        if (r_state == StInit) begin
            r_regs[r_init_cnt] <= DATA_W'(r_init_cnt);
        end else begin
            for (int p = 0; p < NWRITE; p++) begin
                if (w_commit[p]) begin
                    r_regs[w_waddr[p]] <= w_wdata[p];
                end
            end
        end
    end

`ifdef REGFILE_TRACE_EN
    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            for (int p = 0; p < NWRITE; p++) begin
                if (w_commit[p]) begin
                    $display("W%0d r%0d=%h", p, w_waddr[p], w_wdata[p]);
                end
            end
            if ((r_state == StInit) && (r_init_cnt == '1)) begin
                $display("RF ready");
            end
        end
    end
`else
`endif

    assign o_rd_data     = r_rd_data;
    assign o_ready       = r_ready;
    assign o_wr_conflict = r_wr_conflict;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default 32x32 2R/2W instance plus a 16x16 4R/2W instance.
module tb_regfile_mp;

    logic        clk;
    logic        rst_n;

    logic [9:0]  m_rd_addr;
    logic [63:0] m_rd_data;
    logic [1:0]  m_wr_en;
    logic [9:0]  m_wr_addr;
    logic [63:0] m_wr_data;
    logic        m_ready;
    logic        m_conf;

    logic [15:0] s_rd_addr;
    logic [63:0] s_rd_data;
    logic [1:0]  s_wr_en;
    logic [7:0]  s_wr_addr;
    logic [31:0] s_wr_data;
    logic        s_ready;
    logic        s_conf;

    int n_vec;
    int n_bad;

    regfile_mp dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_rd_addr     (m_rd_addr),
        .o_rd_data     (m_rd_data),
        .i_wr_en       (m_wr_en),
        .i_wr_addr     (m_wr_addr),
        .i_wr_data     (m_wr_data),
        .o_ready       (m_ready),
        .o_wr_conflict (m_conf)
    );

    regfile_mp #(
        .DATA_W (16),
        .ADDR_W (4),
        .NREAD  (4),
        .NWRITE (2)
    ) dut_s (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_rd_addr     (s_rd_addr),
        .o_rd_data     (s_rd_data),
        .i_wr_en       (s_wr_en),
        .i_wr_addr     (s_wr_addr),
        .i_wr_data     (s_wr_data),
        .o_ready       (s_ready),
        .o_wr_conflict (s_conf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic        ec;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Runs 40 cycles from reset release, attempting writes during INIT, and records
    // the first cycle each instance reports ready (-1 if never).
    task automatic wait_ready(output int cm, output int cs);
        cm = -1;
        cs = -1;
        m_rd_addr = {5'd3, 5'd3};
        s_rd_addr = {4'd9, 4'd9, 4'd9, 4'd9};
        for (int c = 1; c <= 40; c++) begin
            m_wr_en   = (c < 20) ? 2'b11 : 2'b00;
            m_wr_addr = {5'd3, 5'd3};
            m_wr_data = {32'hBAD0_0001, 32'hBAD0_0000};
            s_wr_en   = (c < 10) ? 2'b11 : 2'b00;
            s_wr_addr = {4'd9, 4'd9};
            s_wr_data = {16'hBAD1, 16'hBAD0};
            @(posedge clk);
            #1;
            if (cm < 0 && m_ready) cm = c;
            if (cs < 0 && s_ready) cs = c;
            if (!m_ready) begin
                chk("init_rd_m", m_rd_data, 64'h0);
                chk("init_conf_m", {63'h0, m_conf}, 64'h0);
            end
            if (!s_ready) begin
                chk("init_rd_s", s_rd_data, 64'h0);
                chk("init_conf_s", {63'h0, s_conf}, 64'h0);
            end
        end
        m_wr_en = 2'b00;
        s_wr_en = 2'b00;
    endtask

    initial begin
        int cm;
        int cs;
        n_vec = 0;
        n_bad = 0;

        //          we     wa0    wd0           wa1    wd1           ra0    ra1    e0            e1            ec
        vecs[0]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd1,  5'd2,  32'h1,        32'h2,        1'b0};
        vecs[1]  = '{2'b01, 5'd5,  32'hDEADBEEF, 5'd0,  32'h0,        5'd5,  5'd6,  32'hDEADBEEF, 32'h6,        1'b0};
        vecs[2]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
        vecs[3]  = '{2'b11, 5'd7,  32'h11111111, 5'd7,  32'h22222222, 5'd7,  5'd7,  32'h22222222, 32'h22222222, 1'b1};
        vecs[4]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd7,  5'd0,  32'h22222222, 32'h0,        1'b0};
        vecs[5]  = '{2'b11, 5'd0,  32'hFFFFFFFF, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0};
        vecs[6]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 1'b0};
        vecs[7]  = '{2'b11, 5'd30, 32'h12345678, 5'd31, 32'hCAFEF00D, 5'd30, 5'd31, 32'h12345678, 32'hCAFEF00D, 1'b0};
        vecs[8]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd30, 5'd31, 32'h12345678, 32'hCAFEF00D, 1'b0};
        vecs[9]  = '{2'b00, 5'd1,  32'hAAAA,     5'd1,  32'hBBBB,     5'd1,  5'd1,  32'h1,        32'h1,        1'b0};
        vecs[10] = '{2'b01, 5'd9,  32'h99,       5'd0,  32'h0,        5'd8,  5'd9,  32'h8,        32'h99,       1'b0};

        rst_n     = 1'b0;
        m_rd_addr = '0;
        m_wr_en   = '0;
        m_wr_addr = '0;
        m_wr_data = '0;
        s_rd_addr = '0;
        s_wr_en   = '0;
        s_wr_addr = '0;
        s_wr_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd_m", m_rd_data, 64'h0);
        chk("rst_ready_m", {63'h0, m_ready}, 64'h0);
        chk("rst_conf_m", {63'h0, m_conf}, 64'h0);
        chk("rst_ready_s", {63'h0, s_ready}, 64'h0);

        rst_n = 1'b1;
        wait_ready(cm, cs);
        chk("ready_cyc_m", 64'(cm), 64'd32);
        chk("ready_cyc_s", 64'(cs), 64'd16);

        for (int i = 0; i < 32; i++) begin
            m_rd_addr = {5'(31 - i), 5'(i)};
            @(posedge clk);
            #1;
            chk($sformatf("sweep_p0_r%0d", i), {32'h0, m_rd_data[31:0]}, 64'(i));
            chk($sformatf("sweep_p1_r%0d", 31 - i), {32'h0, m_rd_data[63:32]}, 64'(31 - i));
        end

        for (int i = 0; i < 11; i++) begin
            m_wr_en   = vecs[i].we;
            m_wr_addr = {vecs[i].wa1, vecs[i].wa0};
            m_wr_data = {vecs[i].wd1, vecs[i].wd0};
            m_rd_addr = {vecs[i].ra1, vecs[i].ra0};
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_rd0", i), {32'h0, m_rd_data[31:0]}, {32'h0, vecs[i].e0});
            chk($sformatf("v%0d_rd1", i), {32'h0, m_rd_data[63:32]}, {32'h0, vecs[i].e1});
            chk($sformatf("v%0d_conf", i), {63'h0, m_conf}, {63'h0, vecs[i].ec});
        end
        m_wr_en = 2'b00;

        // Small instance: every port reads r9, then a mixed read with boundaries.
        s_rd_addr = {4'd9, 4'd9, 4'd9, 4'd9};
        @(posedge clk);
        #1;
        chk("s_r9_all", s_rd_data, 64'h0009_0009_0009_0009);
        s_rd_addr = {4'd0, 4'd15, 4'd9, 4'd3};
        @(posedge clk);
        #1;
        chk("s_mixed", s_rd_data, 64'h0000_000F_0009_0003);

        // Overwrite r3, then check asynchronous reset clears outputs without a clock edge.
        m_wr_en   = 2'b01;
        m_wr_addr = {5'd0, 5'd3};
        m_wr_data = {32'h0, 32'h33};
        m_rd_addr = {5'd5, 5'd3};
        @(posedge clk);
        #1;
        chk("r3_bypass", m_rd_data, {32'hDEADBEEF, 32'h33});
        m_wr_en = 2'b00;
        rst_n = 1'b0;
        #1;
        chk("async_rd_m", m_rd_data, 64'h0);
        chk("async_ready_m", {63'h0, m_ready}, 64'h0);
        chk("async_rd_s", s_rd_data, 64'h0);
        chk("async_ready_s", {63'h0, s_ready}, 64'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset again 10 cycles into INIT, hold 2 cycles, release.
        m_wr_en   = 2'b11;
        m_wr_addr = {5'd3, 5'd3};
        m_wr_data = {32'hBAD0_0003, 32'hBAD0_0002};
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_ready(cm, cs);
        chk("reinit_ready_cyc_m", 64'(cm), 64'd32);
        chk("reinit_ready_cyc_s", 64'(cs), 64'd16);

        m_rd_addr = {5'd5, 5'd3};
        @(posedge clk);
        #1;
        chk("reinit_r3", {32'h0, m_rd_data[31:0]}, 64'h3);
        chk("reinit_r5", {32'h0, m_rd_data[63:32]}, 64'h5);
        chk("reinit_conf", {63'h0, m_conf}, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
